// File: rtl/divider_iter.sv
// divider_iter: iterative unsigned restoring divider, one quotient bit per clock.
// Valid/ready handshake on both sides, one operation in flight at a time.
// Optional build macro DIVIDER_ITER_DBZ_FAST_EN: a zero divisor skips the
// iteration and presents the divide-by-zero result straight after the accept
// edge. The result values are identical either way.
module divider_iter #(
    parameter int BIT_SZ = 4
) (
    input  logic              clk,
    input  logic              rst_l,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [BIT_SZ-1:0] a,
    input  logic [BIT_SZ-1:0] b,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [BIT_SZ-1:0] q,
    output logic [BIT_SZ-1:0] r,
    output logic              dbz
);

    localparam int CNT_W = $clog2(BIT_SZ);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t            state_reg, state_next;
    logic [BIT_SZ-1:0] div_reg, div_next;
    logic [BIT_SZ-1:0] work_reg, work_next;
    logic [BIT_SZ-1:0] rem_reg, rem_next;
    logic [CNT_W-1:0]  cnt_reg, cnt_next;
    logic [BIT_SZ-1:0] q_reg, q_next;
    logic [BIT_SZ-1:0] r_reg, r_next;
    logic              dbz_reg, dbz_next;

    // One restoring step: the shifted partial remainder is BIT_SZ+1 bits wide,
    // and whenever the trial subtraction is non-negative the difference is
    // below the divisor, so it always fits back into BIT_SZ bits.
    logic [BIT_SZ:0]   shifted;
    logic              q_bit;
    logic [BIT_SZ-1:0] rem_step;
    logic              accept;

    assign in_ready  = (state_reg == IDLE);
    assign out_valid = (state_reg == DONE);
    assign q         = q_reg;
    assign r         = r_reg;
    assign dbz       = dbz_reg;
    assign accept    = in_valid && in_ready;

    // Restoring step datapath: trial = shifted - divisor, keep it if >= 0.
    always_comb begin
        shifted  = {rem_reg, work_reg[BIT_SZ-1]};
        q_bit    = (shifted >= {1'b0, div_reg});
        rem_step = q_bit ? (shifted[BIT_SZ-1:0] - div_reg) : shifted[BIT_SZ-1:0];
    end

    // Next-state and next-datapath decode; defaults hold every register.
    always_comb begin
        state_next = state_reg;
        div_next   = div_reg;
        work_next  = work_reg;
        rem_next   = rem_reg;
        cnt_next   = cnt_reg;
        q_next     = q_reg;
        r_next     = r_reg;
        dbz_next   = dbz_reg;
        case (state_reg)
            IDLE: begin
                if (accept) begin
                    div_next   = b;
                    work_next  = a;
                    rem_next   = '0;
                    cnt_next   = CNT_W'(BIT_SZ - 1);
                    state_next = BUSY;
`ifdef DIVIDER_ITER_DBZ_FAST_EN
                    // Zero divisor: the iteration would only reproduce these.
                    if (b == '0) begin
                        q_next     = '1;
                        r_next     = a;
                        dbz_next   = 1'b1;
                        state_next = DONE;
                    end
`endif
                end
            end
            BUSY: begin
                work_next = {work_reg[BIT_SZ-2:0], q_bit};
                rem_next  = rem_step;
                cnt_next  = cnt_reg - 1'b1;
                if (cnt_reg == '0) begin
                    q_next     = {work_reg[BIT_SZ-2:0], q_bit};
                    r_next     = rem_step;
                    dbz_next   = (div_reg == '0);
                    state_next = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // State and datapath registers; asynchronous reset discards any operation.
    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            state_reg <= IDLE;
            div_reg   <= '0;
            work_reg  <= '0;
            rem_reg   <= '0;
            cnt_reg   <= '0;
            q_reg     <= '0;
            r_reg     <= '0;
            dbz_reg   <= 1'b0;
        end else begin
            state_reg <= state_next;
            div_reg   <= div_next;
            work_reg  <= work_next;
            rem_reg   <= rem_next;
            cnt_reg   <= cnt_next;
            q_reg     <= q_next;
            r_reg     <= r_next;
            dbz_reg   <= dbz_next;
        end
    end

endmodule

// File: doc/divider_iter.md
# divider_iter

Iterative unsigned restoring divider, the inverse of the registered multiplier in the arithmetic datapath: takes an unsigned dividend/divisor pair and returns quotient and remainder. It sits beside the multiplier in the datapath. It uses a valid/ready handshake on both sides because its latency is multi-cycle. It resolves one quotient bit per clock and holds one operation in flight at a time.

## Interface
- BIT_SZ, 4, operand/result width in bits; legal values are 2 to 32.

- clk  input  1  clock; all state updates on the rising edge.
- rst_l  input  1  reset; asynchronous, active-low.
- in_valid  input  1  request valid; a and b are sampled when in_valid && in_ready.
- in_ready  output  1  block is idle and can accept a request.
- a  input  BIT_SZ  dividend, unsigned.
- b  input  BIT_SZ  divisor, unsigned.
- out_valid  output  1  result valid; q, r and dbz are stable while it is high.
- out_ready  input  1  consumer accepts the result when out_valid && out_ready.
- q  output  BIT_SZ  quotient, floor(a/b).
- r  output  BIT_SZ  remainder, a mod b.
- dbz  output  1  divide-by-zero flag for the current result.

## Operation
- The FSM has three states: IDLE, BUSY and DONE.
- in_ready = (state == IDLE), decoded combinationally. out_valid = (state == DONE), registered.
- **IDLE**
  - Accepts a request on the handshake.
  - Latches the divisor. Loads the working quotient/shift register with a and clears the partial remainder.
  - Sets the step counter to BIT_SZ-1 and moves to BUSY.
- **BUSY**, one restoring step per edge:
  - Shift {partial remainder, working register} left by 1.
  - Compute trial = partial remainder − divisor, with width BIT_SZ+1.
  - If trial ≥ 0, the partial remainder takes the trial value and quotient bit = 1. Otherwise the partial remainder is restored and quotient bit = 0.
  - The counter decrements. On the step where the counter is 0, the final values are loaded into q, r and dbz, and the state moves to DONE.
- **DONE**
  - Outputs are held until out_valid && out_ready, then the state moves to IDLE.
  - No new request is accepted in the same cycle, because in_ready is low in DONE.
- **Divide by zero:** dbz = (b == 0). Result is q = {BIT_SZ{1'b1}}, r = a. This is the natural output of the restoring algorithm; the same values are produced with or without the configuration macro.
- **Reset**
  - Asynchronous. Forces IDLE and clears all working registers, counter, q, r and dbz.
  - An in-flight operation is discarded and no result is ever presented for it.
- **Handshake rules**
  - in_valid may toggle freely while in_ready is low; it is ignored.
  - a and b are only sampled at the accept edge.

## Timing
- **Reset values:** out_valid = 0, q = 0, r = 0, dbz = 0, state = IDLE. in_ready reads 1 during and after reset.
- **Latency**
  - Accept at edge T0.
  - BUSY steps occur on edges T1..T(BIT_SZ).
  - out_valid is high after edge T(BIT_SZ): BIT_SZ cycles accept-to-valid.
- **Throughput with out_ready held high:** one result every BIT_SZ+2 cycles. That is accept, BIT_SZ steps, then one DONE cycle that pops and returns to IDLE, and finally in_ready.
- **Backpressure:** DONE holds indefinitely with q, r and dbz unchanged.

## Configuration
- DIVIDER_ITER_DBZ_FAST_EN
  - **Defined:** a request with b == 0 goes from IDLE directly to DONE at the accept edge. It loads q = all ones, r = a, dbz = 1, and out_valid is high after 1 cycle.
  - **Undefined:** b == 0 runs the full BIT_SZ-step sequence. Results are identical and latency is BIT_SZ.
  - Latency for nonzero divisors is unaffected either way.

## Test plan
All scenarios use BIT_SZ = 4.
- Reset then idle: rst_l low for 3 cycles → out_valid = 0, q = 0, r = 0, dbz = 0, in_ready = 1 throughout.
- a = 13, b = 3, out_ready = 1 → out_valid exactly 4 cycles after accept with q = 4, r = 1, dbz = 0; in_ready returns 1 the cycle after the pop.
- Corner values:
  - a = 15, b = 15 → q = 1, r = 0.
  - a = 5, b = 7 → q = 0, r = 5.
  - a = 0, b = 9 → q = 0, r = 0.
  - a = 15, b = 1 → q = 15, r = 0.
- a = 9, b = 0 → q = 15, r = 9, dbz = 1. Latency is 1 cycle with DIVIDER_ITER_DBZ_FAST_EN defined and 4 cycles without it.
- a = 14, b = 4, out_ready held low for 10 cycles → q = 3, r = 2 stable for all 10 cycles, in_ready = 0, in_valid pulses ignored; out_ready = 1 → pop, next request accepted.
- Reset mid-operation: assert rst_l low 2 cycles after accepting a = 11, b = 2 → outputs cleared immediately, no out_valid afterwards; a new request a = 11, b = 2 → q = 5, r = 1.
